// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W = 16;
  localparam int IR_W = 8;
  localparam logic [IR_W-1:0] HALT_OPCODE = 8'hAE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    INC  = 2'd2,
    DONE = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_behave_if.sv
// Sequencer and memory-side signals of the fetch stage; master is the fetch unit.
interface fetch_unit_behave_if;
  import fetch_pkg::*;

  logic            fetch_req;
  logic            fetch_done;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_value;
  logic [PC_W-1:0] pc;
  logic [IR_W-1:0] instruction_reg;
  logic [PC_W-1:0] mem_addr;
  logic            mem_rd;
  logic [IR_W-1:0] mem_rdata;
  logic            mem_ready;
  logic            halted;

  modport master (
    input  fetch_req, pc_load, pc_load_value, mem_rdata, mem_ready,
    output fetch_done, pc, instruction_reg, mem_addr, mem_rd, halted
  );

  modport slave (
    output fetch_req, pc_load, pc_load_value, mem_rdata, mem_ready,
    input  fetch_done, pc, instruction_reg, mem_addr, mem_rd, halted
  );

endinterface

// File: rtl/pc_incrementer_behave.sv
// Combinational program-counter +1, wrapping 0xFFFF to 0x0000 without a carry flag.
module pc_incrementer_behave
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc_in,
  output logic [PC_W-1:0] pc_next
);

  assign pc_next = pc_in + {{(PC_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/fetch_unit_behave.sv
// Instruction fetch stage: PC, opcode read with relay settle hold, instruction register.
// Optional HALT opcode detection is built when FETCH_HALT_DETECT_EN is defined.
module fetch_unit_behave
  import fetch_pkg::*;
#(
  parameter int READ_HOLD_CYCLES = 2
) (
  input  logic                clock,
  input  logic                reset,
  fetch_unit_behave_if.master bus
);

  localparam logic [3:0] HOLD_MAX  = 4'(READ_HOLD_CYCLES);
  localparam logic [3:0] HOLD_LAST = 4'(READ_HOLD_CYCLES - 1);

  fetch_state_e    state_r;
  fetch_state_e    next_state_s;
  logic [3:0]      hold_cnt_r;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc_s;
  logic [IR_W-1:0] ir_r;
  logic [PC_W-1:0] mem_addr_r;
  logic            mem_rd_r;
  logic            fetch_done_r;
  logic            mem_rd_s;
  logic            done_s;
  logic            hold_ok_s;
  logic            start_s;
  logic            ir_load_s;
  logic            halt_block_s;

  pc_incrementer_behave u_pc_inc (
    .pc_in   (pc_r),
    .pc_next (pc_inc_s)
  );

  assign hold_ok_s = (hold_cnt_r >= HOLD_LAST);
  assign start_s   = (state_r == IDLE) && (next_state_s == READ);
  assign ir_load_s = (state_r == READ) && (next_state_s == INC);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; a PC load in IDLE takes priority over a fetch request.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.pc_load && bus.fetch_req && !halt_block_s) begin
          next_state_s = READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ: begin
        if (hold_ok_s && bus.mem_ready) begin
          next_state_s = INC;
        end else begin
          next_state_s = READ;
        end
      end
      INC:     next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the strobes can be registered.
  always_comb begin
    mem_rd_s = 1'b0;
    done_s   = 1'b0;
    case (next_state_s)
      READ:    mem_rd_s = 1'b1;
      DONE:    done_s   = 1'b1;
      default: begin
        mem_rd_s = 1'b0;
        done_s   = 1'b0;
      end
    endcase
  end

  // Datapath: PC, hold counter, instruction register and registered bus strobes.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r         <= 16'h0000;
      ir_r         <= 8'h00;
      hold_cnt_r   <= 4'd0;
      mem_addr_r   <= 16'h0000;
      mem_rd_r     <= 1'b0;
      fetch_done_r <= 1'b0;
    end else begin
      mem_rd_r     <= mem_rd_s;
      fetch_done_r <= done_s;
      if ((state_r == IDLE) && bus.pc_load) begin
        pc_r <= bus.pc_load_value;
      end else if (state_r == INC) begin
        pc_r <= pc_inc_s;
      end else begin
        pc_r <= pc_r;
      end
      if (start_s) begin
        hold_cnt_r <= 4'd0;
        mem_addr_r <= pc_r;
      end else if ((state_r == READ) && (hold_cnt_r < HOLD_MAX)) begin
        hold_cnt_r <= hold_cnt_r + 4'd1;
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
      if (ir_load_s) begin
        ir_r <= bus.mem_rdata;
      end else begin
        ir_r <= ir_r;
      end
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halted_r;

  // Sticky halt flag, set in the same edge the HALT opcode is latched.
  always_ff @(posedge clock) begin
    if (reset) begin
      halted_r <= 1'b0;
    end else if (ir_load_s && (bus.mem_rdata == HALT_OPCODE)) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  assign halt_block_s = halted_r;
  assign bus.halted   = halted_r;
`else
  assign halt_block_s = 1'b0;
  assign bus.halted   = 1'b0;
`endif

  assign bus.pc              = pc_r;
  assign bus.instruction_reg = ir_r;
  assign bus.mem_addr        = mem_addr_r;
  assign bus.mem_rd          = mem_rd_r;
  assign bus.fetch_done      = fetch_done_r;

endmodule

// File: tb/tb_fetch_unit_behave.sv
// Directed-vector bench for fetch_unit_behave (default READ_HOLD_CYCLES=2).
module tb_fetch_unit_behave;
  import fetch_pkg::*;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_miss;

  fetch_unit_behave_if bus ();

  fetch_unit_behave #(.READ_HOLD_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_model(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h41;
      16'hFFFF: return 8'h12;
      16'h3000: return 8'h77;
      16'h1234: return 8'h5A;
      16'h2000: return 8'hAE;
      default:  return 8'h00;
    endcase
  endfunction

  assign bus.mem_rdata = mem_model(bus.mem_addr);

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    bus.fetch_req     = 1'b0;
    bus.pc_load       = 1'b0;
    bus.pc_load_value = 16'h0000;
    bus.mem_ready     = 1'b1;
    step();
    step();
    check_vec("rst_pc", 32'(bus.pc), 32'h0000);
    check_vec("rst_ir", 32'(bus.instruction_reg), 32'h00);
    check_vec("rst_rd", 32'(bus.mem_rd), 32'h0);
    check_vec("rst_addr", 32'(bus.mem_addr), 32'h0000);
    check_vec("rst_done", 32'(bus.fetch_done), 32'h0);
    check_vec("rst_halt", 32'(bus.halted), 32'h0);
    reset = 1'b0;

    // Basic fetch from 0x0000.
    bus.fetch_req = 1'b1;
    step();
    check_vec("f1_rd_c1", 32'(bus.mem_rd), 32'h1);
    check_vec("f1_addr", 32'(bus.mem_addr), 32'h0000);
    step();
    check_vec("f1_rd_c2", 32'(bus.mem_rd), 32'h1);
    bus.fetch_req = 1'b0;
    step();
    check_vec("f1_rd_c3", 32'(bus.mem_rd), 32'h0);
    check_vec("f1_ir", 32'(bus.instruction_reg), 32'h41);
    check_vec("f1_done_c3", 32'(bus.fetch_done), 32'h0);
    check_vec("f1_pc_c3", 32'(bus.pc), 32'h0000);
    step();
    check_vec("f1_done_c4", 32'(bus.fetch_done), 32'h1);
    check_vec("f1_pc_c4", 32'(bus.pc), 32'h0001);
    step();
    check_vec("f1_done_c5", 32'(bus.fetch_done), 32'h0);

    // Jump to 0xFFFF and fetch; PC wraps.
    bus.pc_load = 1'b1;
    bus.pc_load_value = 16'hFFFF;
    step();
    check_vec("f2_pcload", 32'(bus.pc), 32'hFFFF);
    bus.pc_load = 1'b0;
    bus.fetch_req = 1'b1;
    step();
    check_vec("f2_addr", 32'(bus.mem_addr), 32'hFFFF);
    bus.fetch_req = 1'b0;
    step();
    step();
    check_vec("f2_ir", 32'(bus.instruction_reg), 32'h12);
    step();
    check_vec("f2_done", 32'(bus.fetch_done), 32'h1);
    check_vec("f2_wrap", 32'(bus.pc), 32'h0000);
    step();

    // Memory not ready for 5 cycles past the hold.
    bus.pc_load = 1'b1;
    bus.pc_load_value = 16'h3000;
    step();
    bus.pc_load = 1'b0;
    bus.mem_ready = 1'b0;
    bus.fetch_req = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      bus.fetch_req = 1'b0;
      check_vec($sformatf("f3_rd_c%0d", i), 32'(bus.mem_rd), 32'h1);
      check_vec($sformatf("f3_addr_c%0d", i), 32'(bus.mem_addr), 32'h3000);
      check_vec($sformatf("f3_done_c%0d", i), 32'(bus.fetch_done), 32'h0);
    end
    bus.mem_ready = 1'b1;
    step();
    check_vec("f3_ir", 32'(bus.instruction_reg), 32'h77);
    check_vec("f3_done_c8", 32'(bus.fetch_done), 32'h0);
    step();
    check_vec("f3_done_c9", 32'(bus.fetch_done), 32'h1);
    check_vec("f3_pc", 32'(bus.pc), 32'h3001);
    step();

    // PC load and fetch request together: load wins, fetch follows.
    bus.pc_load = 1'b1;
    bus.pc_load_value = 16'h1234;
    bus.fetch_req = 1'b1;
    step();
    check_vec("f4_pc", 32'(bus.pc), 32'h1234);
    check_vec("f4_nord", 32'(bus.mem_rd), 32'h0);
    bus.pc_load = 1'b0;
    step();
    check_vec("f4_rd", 32'(bus.mem_rd), 32'h1);
    check_vec("f4_addr", 32'(bus.mem_addr), 32'h1234);
    bus.fetch_req = 1'b0;
    step();
    step();
    check_vec("f4_ir", 32'(bus.instruction_reg), 32'h5A);
    step();
    check_vec("f4_done", 32'(bus.fetch_done), 32'h1);
    check_vec("f4_pcinc", 32'(bus.pc), 32'h1235);
    step();

    // Reset in READ abandons the fetch.
    bus.fetch_req = 1'b1;
    step();
    check_vec("f5_rd", 32'(bus.mem_rd), 32'h1);
    reset = 1'b1;
    bus.fetch_req = 1'b0;
    step();
    check_vec("f5_rd_off", 32'(bus.mem_rd), 32'h0);
    check_vec("f5_pc", 32'(bus.pc), 32'h0000);
    check_vec("f5_ir", 32'(bus.instruction_reg), 32'h00);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("f5_nodone_%0d", i), 32'(bus.fetch_done), 32'h0);
      step();
    end

    // HALT opcode at 0x2000 with fetch_req held through DONE.
    bus.pc_load = 1'b1;
    bus.pc_load_value = 16'h2000;
    step();
    bus.pc_load = 1'b0;
    bus.fetch_req = 1'b1;
    step();
    step();
    step();
    check_vec("f6_ir", 32'(bus.instruction_reg), 32'hAE);
`ifdef FETCH_HALT_DETECT_EN
    check_vec("f6_halted", 32'(bus.halted), 32'h1);
`else
    check_vec("f6_halted", 32'(bus.halted), 32'h0);
`endif
    step();
    check_vec("f6_done", 32'(bus.fetch_done), 32'h1);
    check_vec("f6_pc", 32'(bus.pc), 32'h2001);
    step();
    check_vec("f6_rd_c5", 32'(bus.mem_rd), 32'h0);
    step();
`ifdef FETCH_HALT_DETECT_EN
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("f6_blocked_%0d", i), 32'(bus.mem_rd), 32'h0);
      step();
    end
    bus.fetch_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("f6_halt_clr", 32'(bus.halted), 32'h0);
`else
    check_vec("f6_refetch", 32'(bus.mem_rd), 32'h1);
    check_vec("f6_refetch_addr", 32'(bus.mem_addr), 32'h2001);
    bus.fetch_req = 1'b0;
    step();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
